// File: rtl/i2c_pkg.sv
// Shared I2C definitions: controller FSM states and SCL phase encoding.
// Imported by the master controller, its phase generator and the companion slave.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        WDATA,
        WACK,
        RDATA,
        MNACK,
        STOP
    } i2c_state_t;

    localparam logic [1:0] PH_LOW  = 2'd0;
    localparam logic [1:0] PH_RISE = 2'd1;
    localparam logic [1:0] PH_HIGH = 2'd2;
    localparam logic [1:0] PH_FALL = 2'd3;

    // SCL level for an ordinary data/ack bit in the given quarter phase
    function automatic logic scl_level(input logic [1:0] phase);
        return (phase == PH_RISE) || (phase == PH_HIGH);
    endfunction

endpackage

// File: rtl/i2c_phase_gen.sv
// Quarter-period timebase: QDIV clk per phase, 4 phases per SCL bit.
// Outputs are decoded from registered counters; counters hold at zero while run is low.
module i2c_phase_gen
    import i2c_pkg::*;
#(
    parameter int QDIV = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    output logic [1:0] phase,
    output logic       sample,
    output logic       bit_end
);

    localparam int QW = $clog2(QDIV);

    logic [QW-1:0] qcnt;
    logic          qlast;

    assign qlast = (qcnt == QW'(QDIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qcnt  <= '0;
            phase <= PH_LOW;
        end else if (!run) begin
            qcnt  <= '0;
            phase <= PH_LOW;
        end else if (qlast) begin
            qcnt  <= '0;
            phase <= phase + 2'd1;
        end else begin
            qcnt  <= qcnt + QW'(1);
        end
    end

    assign sample  = qlast && (phase == PH_HIGH);
    assign bit_end = qlast && (phase == PH_FALL);

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address+rw, one data byte (write or read), STOP.
// One command at a time; cmd_ready drops for the whole transaction, done pulses at the end.
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int QDIV = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic [7:0] rdata,
    output logic       done,
    output logic       ack_err,
    output logic       busy,
    output logic       scl_o,
    output logic       sda_oe,
    input  logic       sda_i
);

    i2c_state_t state, state_n;
    logic [1:0] phase;
    logic       sample, bit_end;
    logic [2:0] bit_cnt;
    logic [7:0] sh;
    logic [7:0] wdata_q;
    logic       rw_q;
    logic       accept;
    logic       last_bit;

    assign cmd_ready = (state == IDLE) && !done;
    assign busy      = (state != IDLE) || done;
    assign accept    = cmd_valid && cmd_ready;
    assign last_bit  = bit_end && (bit_cnt == 3'd7);

    i2c_phase_gen #(.QDIV(QDIV)) u_phase (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (state != IDLE),
        .phase   (phase),
        .sample  (sample),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        scl_o   = 1'b1;
        sda_oe  = 1'b0;
        case (state)
            IDLE: if (accept) state_n = START;
            START: begin
                sda_oe = phase[1];
                if (bit_end) state_n = ADDR;
            end
            ADDR: begin
                scl_o  = scl_level(phase);
                sda_oe = ~sh[7];
                if (last_bit) state_n = ADDR_ACK;
            end
            ADDR_ACK: begin
                scl_o = scl_level(phase);
                if (bit_end) state_n = ack_err ? STOP : (rw_q ? RDATA : WDATA);
            end
            WDATA: begin
                scl_o  = scl_level(phase);
                sda_oe = ~sh[7];
                if (last_bit) state_n = WACK;
            end
            WACK: begin
                scl_o = scl_level(phase);
                if (bit_end) state_n = STOP;
            end
            RDATA: begin
                scl_o = scl_level(phase);
                if (last_bit) state_n = MNACK;
            end
            MNACK: begin
                scl_o = scl_level(phase);
                if (bit_end) state_n = STOP;
            end
            STOP: begin
                // SDA held low through the SCL rise, released once SCL is high
                scl_o  = (phase != PH_LOW);
                sda_oe = ~phase[1];
                if (bit_end) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q    <= 1'b0;
            wdata_q <= 8'h00;
            sh      <= 8'h00;
            bit_cnt <= 3'd0;
            ack_err <= 1'b0;
            rdata   <= 8'h00;
            done    <= 1'b0;
        end else begin
            done <= (state == STOP) && bit_end;
            if (accept) begin
                rw_q    <= cmd_rw;
                wdata_q <= cmd_wdata;
                sh      <= {cmd_addr, cmd_rw};
                bit_cnt <= 3'd0;
                ack_err <= 1'b0;
            end
            if (sample && ((state == ADDR_ACK) || (state == WACK)) && sda_i)
                ack_err <= 1'b1;
            if (sample && (state == RDATA))
                sh <= {sh[6:0], sda_i};
            if (bit_end) begin
                case (state)
                    ADDR, WDATA: begin
                        sh      <= {sh[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    ADDR_ACK: sh <= wdata_q;
                    RDATA: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) rdata <= sh;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: behavioural bus slave, directed table and randomized transactions.
module tb_i2c_master_ctrl;

    localparam int         Q        = 2;
    localparam logic [6:0] SLV_ADDR = 7'h55;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_rw = 1'b0;
    logic [6:0] cmd_addr = 7'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       cmd_ready, done, ack_err, busy, scl_o, sda_oe, sda_i;
    logic [7:0] rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural slave at SLV_ADDR, observed through the wired-AND SDA line
    logic       slv_pull = 1'b0;
    logic       pscl = 1'b1;
    logic       psda = 1'b1;
    int         k = 0;
    logic [7:0] sr = 8'h00;
    logic [7:0] slv_dout = 8'h00;
    logic [7:0] slv_rbyte = 8'h00;
    logic       slv_ack = 1'b0;
    logic       slv_rd = 1'b0;
    int         n_start = 0;
    int         n_stop = 0;
    logic       bits[$];

    assign sda_i = !(sda_oe || slv_pull);

    always #5 clk = ~clk;

    i2c_master_ctrl #(.QDIV(Q)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rw    (cmd_rw),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rdata     (rdata),
        .done      (done),
        .ack_err   (ack_err),
        .busy      (busy),
        .scl_o     (scl_o),
        .sda_oe    (sda_oe),
        .sda_i     (sda_i)
    );

    always @(negedge clk) begin
        logic ln;
        ln = !(sda_oe || slv_pull);
        if (pscl && scl_o && psda && !ln) begin
            n_start++;
            k = 0;
            slv_ack = 1'b0;
            slv_dout = 8'h00;
            bits.delete();
        end else if (pscl && scl_o && !psda && ln) begin
            n_stop++;
        end else if (!pscl && scl_o) begin
            bits.push_back(ln);
            if (k < 8) sr = {sr[6:0], ln};
            if (k >= 9 && k <= 16 && slv_ack && !slv_rd) slv_dout = {slv_dout[6:0], ln};
            if (k == 7) begin
                slv_ack = (sr[7:1] == SLV_ADDR);
                slv_rd  = sr[0];
            end
            k++;
        end else if (pscl && !scl_o) begin
            slv_pull = 1'b0;
            if (k == 8 && slv_ack) slv_pull = 1'b1;
            if (k >= 9 && k <= 16 && slv_ack && slv_rd) slv_pull = !slv_rbyte[16 - k];
            if (k == 17 && slv_ack && !slv_rd) slv_pull = 1'b1;
        end
        pscl = scl_o;
        psda = !(sda_oe || slv_pull);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!cmd_ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " ready"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic run_txn(input logic rw, input logic [6:0] addr, input logic [7:0] wdata,
                           input logic [7:0] rbyte, input logic exp_err,
                           input logic [7:0] exp_rdata, input logic hold, input string tag);
        int         n, s0, p0, exp_len, exp_rises;
        logic [7:0] got_a, got_d;
        slv_rbyte = rbyte;
        wait_ready(tag);
        cmd_rw = rw; cmd_addr = addr; cmd_wdata = wdata; cmd_valid = 1'b1;
        s0 = n_start; p0 = n_stop;
        @(posedge clk); #1;
        chk({tag, " busy after accept"}, 32'(busy), 32'd1);
        chk({tag, " ready after accept"}, 32'(cmd_ready), 32'd0);
        if (!hold) cmd_valid = 1'b0;
        n = 0;
        while (!done && n < 200 * Q) begin
            cmd_rw = 1'($urandom); cmd_addr = 7'($urandom); cmd_wdata = 8'($urandom);
            @(posedge clk); #1;
            n++;
        end
        cmd_valid = 1'b0;
        // START + (addr + ack) [+ (data + ack)] + STOP bits, 4 quarters each
        exp_len   = exp_err ? (1 + 9 + 1) * 4 * Q : (1 + 9 + 9 + 1) * 4 * Q;
        exp_rises = exp_err ? 9 + 1 : 18 + 1;
        chk({tag, " cycles to done"}, 32'(n), 32'(exp_len));
        chk({tag, " ack_err"}, 32'(ack_err), 32'(exp_err));
        chk({tag, " rdata"}, 32'(rdata), 32'(exp_rdata));
        chk({tag, " busy in done cycle"}, 32'(busy), 32'd1);
        chk({tag, " start count"}, 32'(n_start - s0), 32'd1);
        chk({tag, " stop count"}, 32'(n_stop - p0), 32'd1);
        chk({tag, " scl rises"}, 32'(bits.size()), 32'(exp_rises));
        if (bits.size() >= 9) begin
            got_a = 8'h00;
            for (int i = 0; i < 8; i++) got_a = {got_a[6:0], bits[i]};
            chk({tag, " addr byte on bus"}, 32'(got_a), 32'({addr, rw}));
        end
        if (!exp_err && bits.size() >= 18) begin
            if (!rw) begin
                got_d = 8'h00;
                for (int i = 9; i < 17; i++) got_d = {got_d[6:0], bits[i]};
                chk({tag, " data byte on bus"}, 32'(got_d), 32'(wdata));
                chk({tag, " slave data_out"}, 32'(slv_dout), 32'(wdata));
            end else begin
                chk({tag, " master nack released"}, 32'(bits[17]), 32'd1);
            end
        end
        @(posedge clk); #1;
        chk({tag, " done one cycle"}, 32'(done), 32'd0);
        chk({tag, " idle busy"}, 32'(busy), 32'd0);
        chk({tag, " idle ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, " idle lines"}, 32'({scl_o, sda_oe}), 32'b10);
    endtask

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] rbyte;
        logic       err;
        logic [7:0] rdata;
        logic       hold;
    } vec_t;

    initial begin
        vec_t       vecs[5];
        logic [7:0] model_rdata;
        logic       rw, ack;
        logic [6:0] addr;
        logic [7:0] wd, rb;
        int         p0;

        vecs[0] = '{rw: 1'b0, addr: 7'h55, wdata: 8'hCC, rbyte: 8'h00, err: 1'b0, rdata: 8'h00, hold: 1'b0};
        vecs[1] = '{rw: 1'b1, addr: 7'h55, wdata: 8'h00, rbyte: 8'hA5, err: 1'b0, rdata: 8'hA5, hold: 1'b0};
        vecs[2] = '{rw: 1'b0, addr: 7'h12, wdata: 8'h5A, rbyte: 8'h00, err: 1'b1, rdata: 8'hA5, hold: 1'b0};
        vecs[3] = '{rw: 1'b1, addr: 7'h12, wdata: 8'h00, rbyte: 8'h3C, err: 1'b1, rdata: 8'hA5, hold: 1'b0};
        vecs[4] = '{rw: 1'b0, addr: 7'h55, wdata: 8'h81, rbyte: 8'h00, err: 1'b0, rdata: 8'hA5, hold: 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset scl_o", 32'(scl_o), 32'd1);
        chk("reset sda_oe", 32'(sda_oe), 32'd0);
        chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset ack_err", 32'(ack_err), 32'd0);
        chk("reset rdata", 32'(rdata), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++)
            run_txn(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].rbyte,
                    vecs[i].err, vecs[i].rdata, vecs[i].hold, $sformatf("vec%0d", i));

        // Reset while WDATA bit 4 is on the bus (bit 14 counting START as bit 0)
        wait_ready("abort");
        cmd_rw = 1'b0; cmd_addr = SLV_ADDR; cmd_wdata = 8'h00; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (14 * 4 * Q) @(posedge clk);
        #1;
        chk("abort pre scl_o", 32'(scl_o), 32'd0);
        chk("abort pre sda_oe", 32'(sda_oe), 32'd1);
        p0 = n_stop;
        rst_n = 1'b0;
        #1;
        chk("abort scl_o", 32'(scl_o), 32'd1);
        chk("abort sda_oe", 32'(sda_oe), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort ready after release", 32'(cmd_ready), 32'd1);
        chk("abort rdata cleared", 32'(rdata), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("abort no stop", 32'(n_stop - p0), 32'd0);
        chk("abort stays idle", 32'(busy), 32'd0);

        model_rdata = 8'h00;
        for (int i = 0; i < 10; i++) begin
            rw   = 1'($urandom);
            addr = ($urandom_range(0, 2) != 0) ? SLV_ADDR : 7'($urandom);
            wd   = 8'($urandom);
            rb   = 8'($urandom);
            ack  = (addr == SLV_ADDR);
            if (rw && ack) model_rdata = rb;
            run_txn(rw, addr, wd, rb, !ack, model_rdata, 1'($urandom_range(0, 1)),
                    $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
